gigatron_mem_sched: RTL and testbench

- Time-slot scheduler that shares one synchronous single-port 128 KB RAM between the gigatron CPU core and a host port (debugger / program loader).
- Divides the system clock into a fixed 4-phase CPU cycle and generates the CPU clock-enable.
- Performs the CPU's pending write and its operand read in dedicated slots and gives the host one access per CPU cycle.
- Applies the ctrl[7:6] memory-bank mapping and supports halting the CPU for host access.

---
 rtl/gigatron_mem_sched.sv | 176 +++++++++++++++++
 tb/tb_gigatron_mem_sched.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gigatron_mem_sched.sv
// gigatron_mem_sched
// Shares one synchronous single-port RAM between the gigatron CPU core and a
// host port. Every CPU cycle is four system clocks:
//   ph0 CPU write slot, ph1 CPU read slot, ph2 host slot, ph3 CPU clock-enable.
// RAM address/strobe outputs are driven combinationally during their slot so
// the RAM samples them on the edge that ends the slot; read data returns one
// clock later and is registered toward the CPU (end of ph2) or host (end of ph3).
module gigatron_mem_sched #(
    parameter int         ADDR_W       = 17,
    parameter logic [1:0] BANK_DEFAULT = 2'b01
) (
    input  logic              clock,
    input  logic              rst_n,
    output logic              cpu_ce,
    input  logic [15:0]       cpu_addr_r,
    input  logic [15:0]       cpu_addr_w,
    input  logic              cpu_we,
    input  logic [7:0]        cpu_data_o,
    output logic [7:0]        cpu_data_i,
    input  logic [1:0]        cpu_bank,
    input  logic              host_halt,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [7:0]        host_wdata,
    output logic [7:0]        host_rdata,
    output logic              host_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {
        PH_WRITE = 2'd0,
        PH_READ  = 2'd1,
        PH_HOST  = 2'd2,
        PH_CE    = 2'd3
    } phase_t;

    phase_t phase_reg;
    phase_t phase_next;

    // run_reg stays low for the slot that immediately follows reset so that
    // every output is quiet on the clock after reset, even if the CPU side
    // still presents a write request.
    logic run_reg;
    // CPU write of the current instruction already reached RAM.
    logic wr_done_reg;
    // Host access was put on the RAM port in ph2 of this CPU cycle.
    logic host_issued_reg;
    logic host_rd_reg;

    // Map a 16-bit CPU address into the physical RAM. The lower 32 KB is
    // fixed; the upper 32 KB selects a bank from ctrl[7:6], with bank code 00
    // redirected to the default bank so that bank 0 never aliases the low half.
    function automatic logic [ADDR_W-1:0] map_cpu(input logic [15:0] a,
                                                  input logic [1:0]  bank);
        logic [ADDR_W-1:0] phys;
        logic [1:0]        sel;
        sel  = (bank == 2'b00) ? BANK_DEFAULT : bank;
        phys = '0;
        phys[14:0] = a[14:0];
        if (a[15]) begin
            phys[16:15] = sel;
        end
        return phys;
    endfunction

    // Phase register: free-running 4-phase counter, also while halted.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            phase_reg <= PH_WRITE;
        end else begin
            phase_reg <= phase_next;
        end
    end

    // Next phase: simple wrap-around sequence ph0 -> ph1 -> ph2 -> ph3 -> ph0.
    always_comb begin
        phase_next = PH_WRITE;
        case (phase_reg)
            PH_WRITE: phase_next = PH_READ;
            PH_READ:  phase_next = PH_HOST;
            PH_HOST:  phase_next = PH_CE;
            PH_CE:    phase_next = PH_WRITE;
            default:  phase_next = PH_WRITE;
        endcase
    end

    // Slot outputs: drive the RAM port and cpu_ce for the current phase.
    // rst_n gates the port so a strobe never reaches RAM on the edge that
    // resets the scheduler (an interrupted access leaves no trace in memory).
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        cpu_ce    = 1'b0;
        if (run_reg && rst_n) begin
            case (phase_reg)
                PH_WRITE: begin
                    if (cpu_we && !wr_done_reg) begin
                        mem_addr  = map_cpu(cpu_addr_w, cpu_bank);
                        mem_wdata = cpu_data_o;
                        mem_we    = 1'b1;
                    end
                end
                PH_READ: begin
                    mem_addr = map_cpu(cpu_addr_r, cpu_bank);
                end
                PH_HOST: begin
                    if (host_req) begin
                        mem_addr  = host_addr;
                        mem_wdata = host_wdata;
                        mem_we    = host_we;
                    end
                end
                PH_CE: begin
                    cpu_ce = !host_halt;
                end
                default: begin
                    mem_we = 1'b0;
                end
            endcase
        end
    end

    // Datapath: write-once guard, read-data capture and host completion.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            run_reg         <= 1'b0;
            wr_done_reg     <= 1'b0;
            host_issued_reg <= 1'b0;
            host_rd_reg     <= 1'b0;
            cpu_data_i      <= '0;
            host_rdata      <= '0;
            host_ack        <= 1'b0;
        end else begin
            run_reg  <= 1'b1;
            host_ack <= 1'b0;
            case (phase_reg)
                PH_WRITE: begin
                    // Held until the CPU actually advances, so a frozen CPU
                    // does not repeat its write every period.
                    if (mem_we) begin
                        wr_done_reg <= 1'b1;
                    end
                end
                PH_HOST: begin
                    // Data for the ph1 read address is on mem_rdata now.
                    cpu_data_i      <= mem_rdata;
                    host_issued_reg <= host_req;
                    host_rd_reg     <= !host_we;
                end
                PH_CE: begin
                    if (cpu_ce) begin
                        wr_done_reg <= 1'b0;
                    end
                    // Data for the ph2 host address is on mem_rdata now; the
                    // ack lands in the following ph0 only.
                    if (host_issued_reg) begin
                        host_ack <= 1'b1;
                        if (host_rd_reg) begin
                            host_rdata <= mem_rdata;
                        end
                    end
                    host_issued_reg <= 1'b0;
                end
                default: begin
                    host_ack <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gigatron_mem_sched.sv
// Bench for gigatron_mem_sched: a synchronous RAM model on the memory port,
// one task per scenario, and a reference model that tracks memory contents
// per CPU cycle (CPU write, CPU read, host access, clock-enable in that order).
module tb_gigatron_mem_sched;
    logic        clock = 1'b0;
    logic        rst_n;
    logic        cpu_ce;
    logic [15:0] cpu_addr_r;
    logic [15:0] cpu_addr_w;
    logic        cpu_we;
    logic [7:0]  cpu_data_o;
    logic [7:0]  cpu_data_i;
    logic [1:0]  cpu_bank;
    logic        host_halt;
    logic        host_req;
    logic        host_we;
    logic [16:0] host_addr;
    logic [7:0]  host_wdata;
    logic [7:0]  host_rdata;
    logic        host_ack;
    logic [16:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;

    int checks = 0;
    int errors = 0;
    int period_no = 0;

    always #5 clock = ~clock;

    gigatron_mem_sched dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .cpu_ce     (cpu_ce),
        .cpu_addr_r (cpu_addr_r),
        .cpu_addr_w (cpu_addr_w),
        .cpu_we     (cpu_we),
        .cpu_data_o (cpu_data_o),
        .cpu_data_i (cpu_data_i),
        .cpu_bank   (cpu_bank),
        .host_halt  (host_halt),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata),
        .host_ack   (host_ack),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata)
    );

    // Initial RAM content, shared by the RAM model and the reference model.
    function automatic logic [7:0] pattern(input int i);
        logic [16:0] a;
        a = i[16:0];
        return a[7:0] ^ a[15:8] ^ {7'd0, a[16]};
    endfunction

    // Synchronous single-port RAM: data valid one clock after the address.
    logic [7:0] ram [0:131071];
    logic       ram_fill;
    always @(posedge clock) begin
        if (ram_fill) begin
            for (int i = 0; i < 131072; i++) ram[i] <= pattern(i);
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    // Stimulus for one CPU period.
    logic        s_we;
    logic [15:0] s_aw;
    logic [15:0] s_ar;
    logic [7:0]  s_d;
    logic [1:0]  s_bank;
    logic        s_halt;
    logic        s_hreq;
    logic        s_hwe;
    logic [16:0] s_ha;
    logic [7:0]  s_hd;

    // Observations of one period (vectors are indexed by phase).
    logic [3:0]  o_we_v;
    logic [3:0]  o_ce_v;
    logic [3:0]  o_ack_v;
    logic [16:0] o_addr [4];
    logic [7:0]  o_wdata [4];
    logic [7:0]  o_cdi;
    logic        o_ack_n;
    logic [7:0]  o_hrd_n;

    // Reference model state and expectations.
    logic [7:0]  ref_mem [0:131071];
    logic [7:0]  ref_hrd;
    logic        m_done;
    logic        e_we0;
    logic        e_we2;
    logic        e_ce;
    logic        e_ack;
    logic [16:0] e_addr0;
    logic [16:0] e_addr1;
    logic [7:0]  e_cdi;
    logic [7:0]  e_hrd;

    // Physical address by plain arithmetic: low 32 KB identity, upper 32 KB
    // moved to bank*32K with bank 0 standing for bank 1.
    function automatic int map_ref(input int a, input int bank);
        int b;
        b = (bank == 0) ? 1 : bank;
        if (a < 32768) return a;
        return b * 32768 + (a - 32768);
    endfunction

    task automatic model_period();
        int wa;
        int ra;
        e_we0   = s_we && !m_done;
        e_addr0 = '0;
        if (e_we0) begin
            wa          = map_ref(int'(s_aw), int'(s_bank));
            e_addr0     = 17'(wa);
            ref_mem[wa] = s_d;
            m_done      = 1'b1;
        end
        ra      = map_ref(int'(s_ar), int'(s_bank));
        e_addr1 = 17'(ra);
        e_cdi   = ref_mem[ra];
        e_we2   = s_hreq && s_hwe;
        e_ack   = s_hreq;
        if (s_hreq) begin
            if (s_hwe) ref_mem[int'(s_ha)] = s_hd;
            else       ref_hrd = ref_mem[int'(s_ha)];
        end
        e_hrd = ref_hrd;
        e_ce  = !s_halt;
        if (e_ce) m_done = 1'b0;
    endtask

    // Drive one CPU period starting 1 time unit after the ph0 edge, sample
    // each phase at the falling edge, and end 1 unit after the next ph0 edge.
    task automatic run_period();
        cpu_we     = s_we;
        cpu_addr_w = s_aw;
        cpu_addr_r = s_ar;
        cpu_data_o = s_d;
        cpu_bank   = s_bank;
        host_halt  = s_halt;
        host_req   = s_hreq;
        host_we    = s_hwe;
        host_addr  = s_ha;
        host_wdata = s_hd;
        for (int p = 0; p < 4; p++) begin
            @(negedge clock);
            o_we_v[p]  = mem_we;
            o_ce_v[p]  = cpu_ce;
            o_ack_v[p] = host_ack;
            o_addr[p]  = mem_addr;
            o_wdata[p] = mem_wdata;
            if (p == 3) o_cdi = cpu_data_i;
            @(posedge clock);
            #1;
        end
        o_ack_n = host_ack;
        o_hrd_n = host_rdata;
        $display("period %0d: cpu_we=%0b aw=%h ar=%h bank=%0d halt=%0b host_req=%0b host_we=%0b ha=%h | mem_we=%b ce=%b cdi=%h ack=%0b hrd=%h",
                 period_no, s_we, s_aw, s_ar, s_bank, s_halt, s_hreq, s_hwe, s_ha, o_we_v, o_ce_v, o_cdi, o_ack_n, o_hrd_n);
        period_no++;
    endtask

    task automatic idle_stim();
        s_we = 1'b0; s_aw = '0; s_ar = '0; s_d = '0; s_bank = '0;
        s_halt = 1'b0; s_hreq = 1'b0; s_hwe = 1'b0; s_ha = '0; s_hd = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ram_fill = 1'b1;
        idle_stim();
        run_period_inputs_idle();
        repeat (3) @(posedge clock);
        #1;
        ram_fill = 1'b0;
        @(negedge clock);
        checks++;
        if ({cpu_ce, mem_we, host_ack} !== 3'b000) begin
            errors++;
            $display("FAIL reset_strobes got ce/we/ack=%b want 000", {cpu_ce, mem_we, host_ack});
        end
        checks++;
        if ({mem_addr, mem_wdata, cpu_data_i, host_rdata} !== 41'd0) begin
            errors++;
            $display("FAIL reset_data got addr=%h wdata=%h cdi=%h hrd=%h want all 0",
                     mem_addr, mem_wdata, cpu_data_i, host_rdata);
        end
        @(posedge clock);
        #1;
        rst_n = 1'b1;
        ref_hrd = '0;
        m_done = 1'b0;
    endtask

    task automatic run_period_inputs_idle();
        cpu_we = 1'b0; cpu_addr_w = '0; cpu_addr_r = '0; cpu_data_o = '0;
        cpu_bank = '0; host_halt = 1'b0; host_req = 1'b0; host_we = 1'b0;
        host_addr = '0; host_wdata = '0;
    endtask

    task automatic test_idle();
        for (int n = 0; n < 3; n++) begin
            idle_stim();
            model_period();
            run_period();
            checks++;
            if (o_ce_v !== 4'b1000) begin
                errors++;
                $display("FAIL idle_ce period=%0d got=%b want=1000", n, o_ce_v);
            end
            checks++;
            if (o_we_v !== 4'b0000) begin
                errors++;
                $display("FAIL idle_mem_we period=%0d got=%b want=0000", n, o_we_v);
            end
        end
    endtask

    task automatic test_cpu_rw();
        idle_stim();
        s_we = 1'b1; s_aw = 16'h1234; s_d = 8'h5A; s_ar = 16'h0040;
        model_period();
        run_period();
        checks++;
        if (o_we_v !== 4'b0001 || o_addr[0] !== 17'h01234 || o_wdata[0] !== 8'h5A) begin
            errors++;
            $display("FAIL cpu_write got we=%b addr=%h data=%h want we=0001 addr=01234 data=5a",
                     o_we_v, o_addr[0], o_wdata[0]);
        end
        idle_stim();
        s_ar = 16'h1234;
        model_period();
        run_period();
        checks++;
        if (o_cdi !== 8'h5A) begin
            errors++;
            $display("FAIL cpu_readback got=%h want=5a", o_cdi);
        end
        // Write and read of the same address within one CPU cycle.
        idle_stim();
        s_we = 1'b1; s_aw = 16'h9ABC; s_ar = 16'h9ABC; s_d = 8'h3C; s_bank = 2'b10;
        model_period();
        run_period();
        checks++;
        if (o_addr[0] !== 17'h11ABC || o_cdi !== 8'h3C) begin
            errors++;
            $display("FAIL cpu_raw got addr=%h cdi=%h want addr=11abc cdi=3c", o_addr[0], o_cdi);
        end
    endtask

    task automatic test_bank_map();
        logic [15:0] addrs [8];
        logic [16:0] want [8];
        addrs = '{16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        want  = '{17'h08001, 17'h08001, 17'h10001, 17'h18001, 17'h07FFF, 17'h07FFF, 17'h07FFF, 17'h07FFF};
        for (int i = 0; i < 8; i++) begin
            idle_stim();
            s_ar = addrs[i];
            s_bank = 2'(i % 4);
            model_period();
            run_period();
            checks++;
            if (o_addr[1] !== want[i] || o_cdi !== e_cdi) begin
                errors++;
                $display("FAIL bank_map a=%h bank=%0d got addr=%h cdi=%h want addr=%h cdi=%h",
                         addrs[i], i % 4, o_addr[1], o_cdi, want[i], e_cdi);
            end
        end
    endtask

    task automatic test_host();
        idle_stim();
        s_hreq = 1'b1; s_hwe = 1'b1; s_ha = 17'h1FFFF; s_hd = 8'hC3; s_ar = 16'h0100;
        model_period();
        run_period();
        checks++;
        if (o_we_v !== 4'b0100 || o_addr[2] !== 17'h1FFFF || o_wdata[2] !== 8'hC3) begin
            errors++;
            $display("FAIL host_write got we=%b addr=%h data=%h want we=0100 addr=1ffff data=c3",
                     o_we_v, o_addr[2], o_wdata[2]);
        end
        checks++;
        if (o_ack_n !== 1'b1 || o_hrd_n !== e_hrd || o_ce_v !== 4'b1000) begin
            errors++;
            $display("FAIL host_write_ack got ack=%0b hrd=%h ce=%b want ack=1 hrd=%h ce=1000",
                     o_ack_n, o_hrd_n, o_ce_v, e_hrd);
        end
        s_hwe = 1'b0;
        model_period();
        run_period();
        checks++;
        if (o_ack_v !== 4'b0001 || o_ack_n !== 1'b1) begin
            errors++;
            $display("FAIL host_ack_spacing got in-period=%b next=%0b want 0001 then 1", o_ack_v, o_ack_n);
        end
        checks++;
        if (o_hrd_n !== 8'hC3 || o_cdi !== e_cdi || o_ce_v !== 4'b1000) begin
            errors++;
            $display("FAIL host_readback got hrd=%h cdi=%h ce=%b want hrd=c3 cdi=%h ce=1000",
                     o_hrd_n, o_cdi, o_ce_v, e_cdi);
        end
    endtask

    task automatic test_halt();
        int cpu_writes;
        cpu_writes = 0;
        idle_stim();
        s_we = 1'b1; s_aw = 16'h2222; s_ar = 16'h2222; s_d = 8'h77; s_halt = 1'b1;
        for (int n = 0; n < 3; n++) begin
            s_hreq = 1'b1; s_hwe = 1'b0; s_ha = 17'($urandom_range(0, 131071));
            model_period();
            run_period();
            if (o_we_v[0]) cpu_writes++;
            checks++;
            if (o_ce_v !== 4'b0000 || o_ack_n !== 1'b1 || o_hrd_n !== e_hrd || o_cdi !== e_cdi) begin
                errors++;
                $display("FAIL halt_period n=%0d got ce=%b ack=%0b hrd=%h cdi=%h want ce=0000 ack=1 hrd=%h cdi=%h",
                         n, o_ce_v, o_ack_n, o_hrd_n, o_cdi, e_hrd, e_cdi);
            end
        end
        checks++;
        if (cpu_writes !== 1) begin
            errors++;
            $display("FAIL halt_write_once got=%0d want=1", cpu_writes);
        end
        s_halt = 1'b0; s_hreq = 1'b0;
        model_period();
        run_period();
        checks++;
        if (o_ce_v !== 4'b1000 || o_we_v !== 4'b0000 || o_cdi !== 8'h77) begin
            errors++;
            $display("FAIL halt_release got ce=%b we=%b cdi=%h want ce=1000 we=0000 cdi=77",
                     o_ce_v, o_we_v, o_cdi);
        end
    endtask

    task automatic test_reset_mid();
        idle_stim();
        s_hreq = 1'b1; s_hwe = 1'b0; s_ha = 17'h00040;
        run_period_inputs_idle();
        host_req = 1'b1; host_we = 1'b0; host_addr = s_ha;
        @(posedge clock); #1;
        @(posedge clock); #1;
        rst_n = 1'b0;
        @(posedge clock); #1;
        @(negedge clock);
        checks++;
        if ({cpu_ce, mem_we, host_ack} !== 3'b000 ||
            {mem_addr, mem_wdata, cpu_data_i, host_rdata} !== 41'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs got ce=%0b we=%0b ack=%0b addr=%h wdata=%h cdi=%h hrd=%h want all 0",
                     cpu_ce, mem_we, host_ack, mem_addr, mem_wdata, cpu_data_i, host_rdata);
        end
        @(posedge clock); #1;
        rst_n = 1'b1;
        ref_hrd = '0;
        m_done = 1'b0;
        idle_stim();
        model_period();
        run_period();
        checks++;
        if (o_ack_v !== 4'b0000 || o_ack_n !== 1'b0 || o_ce_v !== 4'b1000 || o_hrd_n !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_restart got ack=%b/%0b ce=%b hrd=%h want ack=0000/0 ce=1000 hrd=00",
                     o_ack_v, o_ack_n, o_ce_v, o_hrd_n);
        end
    endtask

    task automatic test_random();
        logic prev_halt;
        prev_halt = 1'b0;
        for (int n = 0; n < 40; n++) begin
            // A frozen CPU keeps presenting the same instruction.
            if (!prev_halt) begin
                s_we   = 1'($urandom_range(0, 1));
                s_aw   = 16'($urandom_range(0, 1) * 32768 + $urandom_range(0, 7));
                s_ar   = 16'($urandom_range(0, 1) * 32768 + $urandom_range(0, 7));
                s_d    = 8'($urandom);
                s_bank = 2'($urandom_range(0, 3));
            end
            s_halt    = ($urandom_range(0, 3) == 0);
            s_hreq    = 1'($urandom_range(0, 1));
            s_hwe     = 1'($urandom_range(0, 1));
            s_ha      = 17'($urandom_range(0, 3) * 32768 + $urandom_range(0, 7));
            s_hd      = 8'($urandom);
            prev_halt = s_halt;
            model_period();
            run_period();
            checks++;
            if (o_we_v !== {1'b0, e_we2, 1'b0, e_we0} ||
                (e_we0 && (o_addr[0] !== e_addr0 || o_wdata[0] !== s_d))) begin
                errors++;
                $display("FAIL rand_write n=%0d got we=%b addr=%h data=%h want we=%b addr=%h data=%h",
                         n, o_we_v, o_addr[0], o_wdata[0], {1'b0, e_we2, 1'b0, e_we0}, e_addr0, s_d);
            end
            checks++;
            if (o_addr[1] !== e_addr1 || o_cdi !== e_cdi) begin
                errors++;
                $display("FAIL rand_cpu_read n=%0d got addr=%h cdi=%h want addr=%h cdi=%h",
                         n, o_addr[1], o_cdi, e_addr1, e_cdi);
            end
            checks++;
            if (s_hreq && (o_addr[2] !== s_ha || (s_hwe && o_wdata[2] !== s_hd))) begin
                errors++;
                $display("FAIL rand_host_slot n=%0d got addr=%h data=%h want addr=%h data=%h",
                         n, o_addr[2], o_wdata[2], s_ha, s_hd);
            end
            checks++;
            if (o_ce_v !== {e_ce, 3'b000} || o_ack_v[3:1] !== 3'b000 ||
                o_ack_n !== e_ack || o_hrd_n !== e_hrd) begin
                errors++;
                $display("FAIL rand_ce_ack n=%0d got ce=%b ack=%b/%0b hrd=%h want ce=%b ack=xxx0->%0b hrd=%h",
                         n, o_ce_v, o_ack_v, o_ack_n, o_hrd_n, {e_ce, 3'b000}, e_ack, e_hrd);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 131072; i++) ref_mem[i] = pattern(i);
        test_reset();
        test_idle();
        test_cpu_rw();
        test_bank_map();
        test_host();
        test_halt();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
